// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard/stall controller for a five-stage pipeline. It is the only source
//   of the write enables and flushes of the IF/ID, ID/EX, EX/MEM and MEM/WB
//   registers and of the PC write enable. It handles load-use bubbles, dcache
//   waits, taken-branch and jump redirects, icache misses and halt drain.
//
//   Optional build macro: HAZARD_PERF_EN adds the stall_cycles / flush_count
//   performance counters (and the CNT_W parameter).
//
//   Ports
//     CLK, nRST                  clock (rising edge), async active-low reset
//     ihit, dhit                 icache / dcache completion strobes
//     exmem_dREN, exmem_dWEN     load / store in MEM stage
//     idex_MemRead, idex_rt      load and its destination in EX stage
//     ifid_rs, ifid_rt           ID-stage source registers
//     branch_taken               branch resolved taken
//     jump_id                    J/JAL/JR decoded in ID
//     halt_wb                    halt reached MEM/WB
//     pc_WEN, *_WEN, *_flush     pipeline register controls (Mealy)
//     halted                     sticky halt flag (registered)
//     stall_cycles, flush_count  perf counters (HAZARD_PERF_EN only)
//
//   state   | meaning
//   RUN     | normal issue, full rule priority evaluated
//   LDUSE   | inserting additional load-use bubbles
//   MEMWAIT | whole pipe frozen until dcache completes
//   HALTED  | pipe frozen forever, left only by reset

module pipe_hazard_ctrl #(
    parameter int REG_W      = 5,
    parameter int LU_BUBBLES = 1
`ifdef HAZARD_PERF_EN
   ,parameter int CNT_W      = 32
`endif
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             exmem_dREN,
    input  logic             exmem_dWEN,
    input  logic             idex_MemRead,
    input  logic [REG_W-1:0] idex_rt,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             branch_taken,
    input  logic             jump_id,
    input  logic             halt_wb,
    output logic             pc_WEN,
    output logic             ifid_WEN,
    output logic             ifid_flush,
    output logic             idex_WEN,
    output logic             idex_flush,
    output logic             exmem_WEN,
    output logic             exmem_flush,
    output logic             memwb_WEN,
    output logic             memwb_flush,
    output logic             halted
`ifdef HAZARD_PERF_EN
   ,output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
`endif
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_LDUSE   = 2'd1,
        S_MEMWAIT = 2'd2,
        S_HALTED  = 2'd3
    } state_t;

    // Action chosen this cycle; drives both the outputs and the next state.
    typedef enum logic [2:0] {
        A_NONE   = 3'd0,
        A_HALT   = 3'd1,
        A_MWAIT  = 3'd2,
        A_STALL  = 3'd3,
        A_BRANCH = 3'd4,
        A_LU     = 3'd5,
        A_JUMP   = 3'd6,
        A_MISS   = 3'd7
    } act_t;

    localparam logic [1:0] LU_CNT_INIT = 2'(LU_BUBBLES - 1);

    state_t     state;
    logic [1:0] cnt;
    act_t       act;
    logic       mem_req;
    logic       lu;

    assign mem_req = exmem_dREN | exmem_dWEN;
    assign lu      = idex_MemRead && (idex_rt != '0) &&
                     ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

    // Rules shared by RUN (after halt/memwait checks) and by MEMWAIT on dhit.
    function automatic act_t issue_rules(input logic br, input logic luh,
                                         input logic jmp, input logic ih);
        if (br)       return A_BRANCH;
        else if (luh) return A_LU;
        else if (jmp) return A_JUMP;
        else if (!ih) return A_MISS;
        else          return A_NONE;
    endfunction

    always_comb begin
        act = A_NONE;
        unique case (state)
            S_RUN: begin
                if (halt_wb)              act = A_HALT;
                else if (mem_req && !dhit) act = A_MWAIT;
                else                      act = issue_rules(branch_taken, lu, jump_id, ihit);
            end
            S_LDUSE:   act = branch_taken ? A_BRANCH : A_LU;
            S_MEMWAIT: act = dhit ? issue_rules(branch_taken, lu, jump_id, ihit) : A_STALL;
            S_HALTED:  act = A_STALL;
            default:   act = A_STALL;
        endcase
    end

    // Mealy outputs. A flushed register always keeps its WEN high so the
    // bubble is actually written.
    always_comb begin
        pc_WEN      = ihit;
        ifid_WEN    = 1'b1;
        idex_WEN    = 1'b1;
        exmem_WEN   = 1'b1;
        memwb_WEN   = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        unique case (act)
            A_HALT, A_MWAIT, A_STALL: begin
                pc_WEN    = 1'b0;
                ifid_WEN  = 1'b0;
                idex_WEN  = 1'b0;
                exmem_WEN = 1'b0;
                memwb_WEN = 1'b0;
            end
            A_BRANCH: begin
                pc_WEN      = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end
            A_LU: begin
                pc_WEN     = 1'b0;
                ifid_WEN   = 1'b0;
                idex_flush = 1'b1;
            end
            A_JUMP: begin
                pc_WEN     = 1'b1;
                ifid_flush = 1'b1;
            end
            A_MISS: begin
                pc_WEN     = 1'b0;
                ifid_flush = 1'b1;
            end
            default: ;
        endcase
        // Outputs are forced low for the whole time reset is asserted, not
        // just from the next edge.
        if (!nRST) begin
            pc_WEN      = 1'b0;
            ifid_WEN    = 1'b0;
            idex_WEN    = 1'b0;
            exmem_WEN   = 1'b0;
            memwb_WEN   = 1'b0;
            ifid_flush  = 1'b0;
            idex_flush  = 1'b0;
            exmem_flush = 1'b0;
            memwb_flush = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= S_RUN;
            cnt    <= 2'd0;
            halted <= 1'b0;
        end else begin
            unique case (act)
                A_HALT: begin
                    state  <= S_HALTED;
                    halted <= 1'b1;
                end
                A_MWAIT: state <= S_MEMWAIT;
                A_STALL: ;
                A_LU: begin
                    if (state == S_LDUSE) begin
                        cnt <= cnt - 2'd1;
                        if (cnt <= 2'd1) state <= S_RUN;
                    end else begin
                        cnt   <= LU_CNT_INIT;
                        state <= (LU_CNT_INIT != 2'd0) ? S_LDUSE : S_RUN;
                    end
                end
                default: begin
                    state <= S_RUN;
                    cnt   <= 2'd0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_WEN && state != S_HALTED) stall_cycles <= stall_cycles + 1'b1;
            if (ifid_flush)                   flush_count  <= flush_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (default parameters, LU_BUBBLES=1).
// Inputs change 1 time unit after a rising edge; outputs are sampled 4 units
// after the edge, well before the next one.

module tb_pipe_hazard_ctrl;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       ihit, dhit, exmem_dREN, exmem_dWEN, idex_MemRead;
    logic [4:0] idex_rt, ifid_rs, ifid_rt;
    logic       branch_taken, jump_id, halt_wb;
    logic       pc_WEN, ifid_WEN, ifid_flush, idex_WEN, idex_flush;
    logic       exmem_WEN, exmem_flush, memwb_WEN, memwb_flush, halted;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    int total = 0;
    int bad   = 0;

    logic [4:0] wen;
    logic [3:0] fl;
    assign wen = {pc_WEN, ifid_WEN, idex_WEN, exmem_WEN, memwb_WEN};
    assign fl  = {ifid_flush, idex_flush, exmem_flush, memwb_flush};

    pipe_hazard_ctrl dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN),
        .idex_MemRead(idex_MemRead), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .branch_taken(branch_taken), .jump_id(jump_id), .halt_wb(halt_wb),
        .pc_WEN(pc_WEN), .ifid_WEN(ifid_WEN), .ifid_flush(ifid_flush),
        .idex_WEN(idex_WEN), .idex_flush(idex_flush),
        .exmem_WEN(exmem_WEN), .exmem_flush(exmem_flush),
        .memwb_WEN(memwb_WEN), .memwb_flush(memwb_flush),
        .halted(halted)
`ifdef HAZARD_PERF_EN
       ,.stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        ihit = 1'b1; dhit = 1'b0; exmem_dREN = 1'b0; exmem_dWEN = 1'b0;
        idex_MemRead = 1'b0; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
        branch_taken = 1'b0; jump_id = 1'b0; halt_wb = 1'b0;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        idle();
        #3;
        total++; if (wen !== 5'b00000) begin bad++; $display("FAIL reset_wen got=%b want=00000", wen); end
        total++; if (fl !== 4'b0000) begin bad++; $display("FAIL reset_flush got=%b want=0000", fl); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b want=0", halted); end
        @(posedge CLK); @(posedge CLK); #1;
        nRST = 1'b1;
        #3;
        total++; if (wen !== 5'b11111) begin bad++; $display("FAIL post_reset_wen got=%b want=11111", wen); end
        total++; if (fl !== 4'b0000) begin bad++; $display("FAIL post_reset_flush got=%b want=0000", fl); end
    endtask

    task automatic test_load_use();
        step(); idle();
        idex_MemRead = 1'b1; idex_rt = 5'd2; ifid_rs = 5'd2; ifid_rt = 5'd9;
        #3;
        total++; if (wen !== 5'b00111) begin bad++; $display("FAIL lu_rs_wen got=%b want=00111", wen); end
        total++; if (fl !== 4'b0100) begin bad++; $display("FAIL lu_rs_flush got=%b want=0100", fl); end
        step(); idle();
        #3;
        total++; if (wen !== 5'b11111) begin bad++; $display("FAIL lu_after_wen got=%b want=11111", wen); end
        total++; if (fl !== 4'b0000) begin bad++; $display("FAIL lu_after_flush got=%b want=0000", fl); end
        // hazard via the second source operand
        step(); idle();
        idex_MemRead = 1'b1; idex_rt = 5'd7; ifid_rs = 5'd3; ifid_rt = 5'd7;
        #3;
        total++; if (wen !== 5'b00111) begin bad++; $display("FAIL lu_rt_wen got=%b want=00111", wen); end
        // register 0 never creates a hazard
        step(); idle();
        idex_MemRead = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
        #3;
        total++; if (wen !== 5'b11111) begin bad++; $display("FAIL lu_r0_wen got=%b want=11111", wen); end
        total++; if (fl !== 4'b0000) begin bad++; $display("FAIL lu_r0_flush got=%b want=0000", fl); end
        // no hazard when EX holds a non-load
        step(); idle();
        idex_MemRead = 1'b0; idex_rt = 5'd4; ifid_rs = 5'd4;
        #3;
        total++; if (wen !== 5'b11111) begin bad++; $display("FAIL nolu_wen got=%b want=11111", wen); end
    endtask

    task automatic test_memwait();
        step(); idle();
        exmem_dREN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #3;
            total++; if (wen !== 5'b00000) begin bad++; $display("FAIL memwait_wen c%0d got=%b want=00000", i, wen); end
            total++; if (fl !== 4'b0000) begin bad++; $display("FAIL memwait_flush c%0d got=%b want=0000", i, fl); end
            step();
        end
        dhit = 1'b1;
        #3;
        total++; if (wen !== 5'b11111) begin bad++; $display("FAIL memwait_dhit_wen got=%b want=11111", wen); end
        step(); idle();
        #3;
        total++; if (wen !== 5'b11111) begin bad++; $display("FAIL memwait_exit_wen got=%b want=11111", wen); end
        // store waits the same way; on dhit a taken branch is honoured
        step(); idle();
        exmem_dWEN = 1'b1;
        #3;
        total++; if (wen !== 5'b00000) begin bad++; $display("FAIL store_wait_wen got=%b want=00000", wen); end
        step();
        dhit = 1'b1; branch_taken = 1'b1;
        #3;
        total++; if (wen !== 5'b11111) begin bad++; $display("FAIL dhit_branch_wen got=%b want=11111", wen); end
        total++; if (fl !== 4'b1110) begin bad++; $display("FAIL dhit_branch_flush got=%b want=1110", fl); end
    endtask

    task automatic test_branch();
        step(); idle();
        branch_taken = 1'b1;
        idex_MemRead = 1'b1; idex_rt = 5'd2; ifid_rs = 5'd2;
        #3;
        total++; if (wen !== 5'b11111) begin bad++; $display("FAIL branch_lu_wen got=%b want=11111", wen); end
        total++; if (fl !== 4'b1110) begin bad++; $display("FAIL branch_lu_flush got=%b want=1110", fl); end
        // jump in ID
        step(); idle();
        jump_id = 1'b1;
        #3;
        total++; if (wen !== 5'b11111) begin bad++; $display("FAIL jump_wen got=%b want=11111", wen); end
        total++; if (fl !== 4'b1000) begin bad++; $display("FAIL jump_flush got=%b want=1000", fl); end
        // icache miss
        step(); idle();
        ihit = 1'b0;
        #3;
        total++; if (wen !== 5'b01111) begin bad++; $display("FAIL imiss_wen got=%b want=01111", wen); end
        total++; if (fl !== 4'b1000) begin bad++; $display("FAIL imiss_flush got=%b want=1000", fl); end
        // load-use outranks a jump in ID
        step(); idle();
        jump_id = 1'b1; idex_MemRead = 1'b1; idex_rt = 5'd5; ifid_rt = 5'd5;
        #3;
        total++; if (wen !== 5'b00111) begin bad++; $display("FAIL lu_over_jump_wen got=%b want=00111", wen); end
        total++; if (fl !== 4'b0100) begin bad++; $display("FAIL lu_over_jump_flush got=%b want=0100", fl); end
    endtask

    task automatic test_halt();
        step(); idle();
        halt_wb = 1'b1; exmem_dREN = 1'b1;
        #3;
        total++; if (wen !== 5'b00000) begin bad++; $display("FAIL halt_wen got=%b want=00000", wen); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt_same_cycle got=%b want=0", halted); end
        for (int i = 0; i < 3; i++) begin
            step(); idle();
            if (i == 2) branch_taken = 1'b1;
            #3;
            total++; if (halted !== 1'b1) begin bad++; $display("FAIL halted c%0d got=%b want=1", i, halted); end
            total++; if (wen !== 5'b00000) begin bad++; $display("FAIL halted_wen c%0d got=%b want=00000", i, wen); end
            total++; if (fl !== 4'b0000) begin bad++; $display("FAIL halted_flush c%0d got=%b want=0000", i, fl); end
        end
    endtask

    task automatic test_reset_memwait();
        // leave HALTED first
        nRST = 1'b0;
        step(); idle();
        nRST = 1'b1;
        #3;
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt_cleared got=%b want=0", halted); end
        step(); idle();
        exmem_dREN = 1'b1;
        step();
        #1;
        total++; if (wen !== 5'b00000) begin bad++; $display("FAIL pre_rst_memwait_wen got=%b want=00000", wen); end
        nRST = 1'b0;
        #1;
        total++; if (wen !== 5'b00000) begin bad++; $display("FAIL rst_mid_wen got=%b want=00000", wen); end
        total++; if (fl !== 4'b0000) begin bad++; $display("FAIL rst_mid_flush got=%b want=0000", fl); end
        idle();
        step();
        nRST = 1'b1;
        #3;
        total++; if (wen !== 5'b11111) begin bad++; $display("FAIL rst_release_wen got=%b want=11111", wen); end
        step();
        #3;
        total++; if (wen !== 5'b11111) begin bad++; $display("FAIL rst_release_run got=%b want=11111", wen); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_release_halted got=%b want=0", halted); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_memwait();
        test_branch();
        test_halt();
        test_reset_memwait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
